mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Multicycle control sequencer for the 16-bit MIPS datapath. It is the issuing side of the ALU slice interface.
- Decodes the 4-bit opcode, walks the classic fetch/decode/execute/memory/writeback states, and drives the 4-bit ALU OP code into the ALU bit-slice chain.
- Consumes the ALU ZERO flag to resolve branches.
- Sequences memory accesses with a ready handshake and counts retired instructions.

Parameters:
- CNT_W, 16, width of retired-instruction counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- OPCODE  in  4  instruction bits [15:12] from IR.
- ZERO  in  1  ALU result-equals-zero flag.
- MEM_READY  in  1  memory access completes this cycle.
- MEM_READ  out  1  memory read strobe.
- MEM_WRITE  out  1  memory write strobe.
- IOR_D  out  1  0 = PC address, 1 = ALUOut address.
- IR_WRITE  out  1  load instruction register.
- PC_EN  out  1  PC write enable (unconditional or resolved branch).
- PC_SRC  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
- ALU_SRC_A  out  1  0 = PC, 1 = register A.
- ALU_SRC_B  out  2  00 = reg B, 01 = constant 2, 10 = sign-ext imm, 11 = sign-ext imm<<1.
- ALU_OP  out  4  to ALU slices; OP[2] = invert B / carry-in.
- REG_DST  out  1  0 = rt, 1 = rd.
- MEM_TO_REG  out  1  0 = ALUOut, 1 = MDR.
- REG_WRITE  out  1  register file write enable.
- INSTR_DONE  out  1  one-cycle pulse on retirement.
- ILLEGAL  out  1  one-cycle pulse when an undefined opcode is decoded.
- INSTR_CNT  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (async, RST_N=0):
  - state = IDLE; INSTR_CNT = 0.
  - All outputs 0 while in IDLE.
  - IDLE -> FETCH unconditionally on the first clock after release.
  - Reset mid-instruction aborts it immediately; no count.
- ALU_OP encoding:
  - ADD = 0000, AND = 0001, OR = 0010, SUB = 0100, SLT = 0111.
  - Any state not listed below drives ADD.
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 SLT (R-type).
  - 0101 ADDI, 0110 LW, 0111 SW, 1000 BEQ, 1001 BNE, 1010 J.
  - 1011-1111 illegal.
- Output decode: outputs are combinational from the state register only (Moore), except the MEM_READY and ZERO qualifications noted in the state list.
- States and actions:
  - FETCH:
    - Always: MEM_READ=1, IOR_D=0, ALU_SRC_A=0, ALU_SRC_B=01, ALU_OP=ADD, PC_SRC=00.
    - IR_WRITE = PC_EN = MEM_READY.
    - Stay while MEM_READY=0; -> DECODE when MEM_READY=1.
  - DECODE:
    - ALU_SRC_A=0, ALU_SRC_B=11, ALU_OP=ADD (branch target into ALUOut).
    - Next: R-type -> EXEC_R; ADDI -> EXEC_I; LW/SW -> MEM_ADDR; BEQ/BNE -> BRANCH; J -> JUMP.
    - Illegal: ILLEGAL=1, -> FETCH, no INSTR_DONE.
  - EXEC_R: ALU_SRC_A=1, ALU_SRC_B=00, ALU_OP per opcode; -> ALU_WB.
  - EXEC_I: ALU_SRC_A=1, ALU_SRC_B=10, ALU_OP=ADD; -> ALU_WB.
  - ALU_WB: REG_WRITE=1, MEM_TO_REG=0, REG_DST=1 for R-type / 0 for ADDI; INSTR_DONE=1; -> FETCH.
  - MEM_ADDR: ALU_SRC_A=1, ALU_SRC_B=10, ALU_OP=ADD; LW -> MEM_RD, SW -> MEM_WR.
  - MEM_RD: MEM_READ=1, IOR_D=1; hold until MEM_READY; -> MEM_WB.
  - MEM_WB: REG_WRITE=1, MEM_TO_REG=1, REG_DST=0; INSTR_DONE=1; -> FETCH.
  - MEM_WR: MEM_WRITE=1, IOR_D=1; hold until MEM_READY; then INSTR_DONE=1, -> FETCH.
  - BRANCH:
    - ALU_SRC_A=1, ALU_SRC_B=00, ALU_OP=SUB, PC_SRC=01.
    - PC_EN = ZERO for BEQ, !ZERO for BNE.
    - INSTR_DONE=1; -> FETCH.
  - JUMP: PC_SRC=10, PC_EN=1; INSTR_DONE=1; -> FETCH.
- Latency with MEM_READY tied high:
  - R-type/ADDI 4 cycles; LW 5; SW 4; BEQ/BNE 3; J 3; illegal 2.
  - Each cycle MEM_READY is low in FETCH, MEM_RD or MEM_WR adds one cycle.
- Strobes: MEM_READ/MEM_WRITE stay asserted and stable until the cycle MEM_READY=1. They are never both high.
- INSTR_CNT:
  - Increments by 1 on every INSTR_DONE cycle.
  - Wraps from 2^CNT_W-1 to 0, no saturation.
- MEM_READY outside FETCH, MEM_RD and MEM_WR is ignored. ZERO outside BRANCH is ignored.

Test Plan:
- Reset release, MEM_READY=1, OPCODE=0000 -> states IDLE, FETCH, DECODE, EXEC_R, ALU_WB; ALU_OP=0000 in EXEC_R; REG_WRITE=1 with REG_DST=1 in ALU_WB; INSTR_CNT=1.
- OPCODE=0110, MEM_READY low 3 cycles in MEM_RD -> MEM_READ/IOR_D held 4 cycles; MEM_WB REG_WRITE=1 and MEM_TO_REG=1; total 8 cycles.
- OPCODE=1000 with ZERO=1 -> BRANCH PC_EN=1, PC_SRC=01, ALU_OP=0100. Repeat with ZERO=0 -> PC_EN=0. OPCODE=1001 -> inverse results.
- OPCODE=1100 -> ILLEGAL pulse in DECODE, back to FETCH next cycle; INSTR_CNT unchanged.
- Preload counter via 65535 retirements, one more -> INSTR_CNT=0.
- RST_N low during MEM_WR with MEM_READY=0 -> MEM_WRITE=0 immediately (asynchronous); state IDLE; INSTR_CNT=0; FETCH on the first edge after release.

Source files
------------

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS-16 control sequencer driving the ALU slice chain, memory handshake and retire counter
module mc_control_fsm #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ior_d,
   output logic             ir_write,
   output logic             pc_en,
   output logic [1:0]       pc_src,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [3:0]       alu_op,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             instr_done,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_cnt
);
   typedef enum logic [3:0] {
      IDLE, FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB,
      MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP
   } state_t;
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_AND = 4'b0001;
   localparam logic [3:0] ALU_OR  = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0100;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   state_t state, state_nx;
   logic is_r;
   logic [3:0] r_op;
   assign is_r = opcode <= 4'd4;
   assign r_op = opcode == 4'd1 ? ALU_SUB :
                 opcode == 4'd2 ? ALU_AND :
                 opcode == 4'd3 ? ALU_OR  :
                 opcode == 4'd4 ? ALU_SLT : ALU_ADD;
   // state register; reset aborts any instruction in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end
   // retired-instruction counter, wraps freely
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          instr_cnt <= '0;
      else if (instr_done) instr_cnt <= instr_cnt + 1'b1;
   end
   // next-state and Moore outputs, with MEM_READY/ZERO qualification where the handshake needs it
   always_comb begin
      state_nx   = state;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ior_d      = 1'b0;
      ir_write   = 1'b0;
      pc_en      = 1'b0;
      pc_src     = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = ALU_ADD;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
      case (state)
         IDLE: state_nx = FETCH;
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_en     = mem_ready;
            state_nx  = mem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            alu_src_b = 2'b11;
            illegal   = opcode > 4'd10;
            state_nx  = is_r                                ? EXEC_R   :
                        opcode == 4'd5                      ? EXEC_I   :
                        opcode == 4'd6 || opcode == 4'd7    ? MEM_ADDR :
                        opcode == 4'd8 || opcode == 4'd9    ? BRANCH   :
                        opcode == 4'd10                     ? JUMP     : FETCH;
         end
         EXEC_R: begin
            alu_src_a = 1'b1;
            alu_op    = r_op;
            state_nx  = ALU_WB;
         end
         EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_nx  = ALU_WB;
         end
         ALU_WB: begin
            reg_write  = 1'b1;
            reg_dst    = is_r;
            instr_done = 1'b1;
            state_nx   = FETCH;
         end
         MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_nx  = opcode == 4'd6 ? MEM_RD : MEM_WR;
         end
         MEM_RD: begin
            mem_read = 1'b1;
            ior_d    = 1'b1;
            state_nx = mem_ready ? MEM_WB : MEM_RD;
         end
         MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            instr_done = 1'b1;
            state_nx   = FETCH;
         end
         MEM_WR: begin
            mem_write  = 1'b1;
            ior_d      = 1'b1;
            instr_done = mem_ready;
            state_nx   = mem_ready ? FETCH : MEM_WR;
         end
         BRANCH: begin
            alu_src_a  = 1'b1;
            alu_op     = ALU_SUB;
            pc_src     = 2'b01;
            pc_en      = opcode[0] ? !zero : zero;
            instr_done = 1'b1;
            state_nx   = FETCH;
         end
         JUMP: begin
            pc_src     = 2'b10;
            pc_en      = 1'b1;
            instr_done = 1'b1;
            state_nx   = FETCH;
         end
         default: state_nx = IDLE;
      endcase
   end
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: randomized scoreboard bench for the multicycle control sequencer
module tb_mc_control_fsm;
   localparam int CNT_W = 6;
   typedef struct packed {
      logic       mr, mw, iord, irw, pcen;
      logic [1:0] pcsrc;
      logic       srca;
      logic [1:0] srcb;
      logic [3:0] aluop;
      logic       rdst, m2r, regw, done, ill;
   } vec_t;
   typedef struct packed {
      vec_t             v;
      logic [CNT_W-1:0] cnt;
   } exp_t;
   logic clk = 1'b0, rst_n = 1'b0, zero = 1'b0, mem_ready = 1'b0, run = 1'b0;
   logic [3:0] opcode = 4'd0;
   logic mem_read, mem_write, ior_d, ir_write, pc_en, alu_src_a, reg_dst, mem_to_reg, reg_write, instr_done, illegal;
   logic [1:0] pc_src, alu_src_b;
   logic [3:0] alu_op;
   logic [CNT_W-1:0] instr_cnt;
   logic [CNT_W-1:0] mcnt;
   vec_t act;
   exp_t sb[$];
   int checks = 0, errors = 0;
   event sample_ev;

   mc_control_fsm #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .mem_read(mem_read), .mem_write(mem_write), .ior_d(ior_d), .ir_write(ir_write),
      .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .instr_done(instr_done), .illegal(illegal), .instr_cnt(instr_cnt)
   );

   always #5 clk = ~clk;

   assign act = {mem_read, mem_write, ior_d, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
                 alu_op, reg_dst, mem_to_reg, reg_write, instr_done, illegal};

   // monitor: every sampled cycle pops one expected output set and compares
   initial forever begin
      exp_t e;
      @(negedge clk or sample_ev);
      if (run) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: actual outputs %b, required none pending", act);
         end else begin
            e = sb.pop_front();
            checks++;
            if (act !== e.v) begin
               errors++;
               $display("FAIL outputs @%0t: actual %b required %b", $time, act, e.v);
            end
            checks++;
            if (instr_cnt !== e.cnt) begin
               errors++;
               $display("FAIL instr_cnt @%0t: actual %0d required %0d", $time, instr_cnt, e.cnt);
            end
         end
         checks++;
         if (mem_read && mem_write) begin
            errors++;
            $display("FAIL strobe_exclusive @%0t: actual read=%b write=%b required not both", $time, mem_read, mem_write);
         end
      end
   end

   function automatic logic [3:0] alu_of(input logic [3:0] op);
      case (op)
         4'd1:    return 4'b0100;
         4'd2:    return 4'b0001;
         4'd3:    return 4'b0010;
         4'd4:    return 4'b0111;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic exp_t mk(input vec_t v, input logic [CNT_W-1:0] c);
      exp_t e;
      e.v   = v;
      e.cnt = c;
      return e;
   endfunction

   task automatic hold_reset();
      rst_n = 1'b0;
      mem_ready = 1'b0;
      sb.delete();
      mcnt = '0;
      sb.push_back(mk('0, '0));
      #1 -> sample_ev;
      repeat (3) begin
         sb.push_back(mk('0, '0));
         @(negedge clk);
      end
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // expected behaviour built phase by phase from the instruction's class and stall counts
   task automatic run_instr(input logic [3:0] op, input int f, input int s, input logic z, input int abort_at);
      vec_t cyc[$];
      logic rdy[$];
      logic zv[$];
      vec_t c;
      logic ill;
      ill = op > 4'd10;
      for (int k = 0; k <= f; k++) begin
         c = '0; c.mr = 1'b1; c.srcb = 2'b01; c.irw = (k == f); c.pcen = (k == f);
         cyc.push_back(c); rdy.push_back(k == f); zv.push_back(1'($urandom));
      end
      c = '0; c.srcb = 2'b11; c.ill = ill;
      cyc.push_back(c); rdy.push_back(1'($urandom)); zv.push_back(1'($urandom));
      if (op <= 4'd5) begin
         c = '0; c.srca = 1'b1;
         if (op == 4'd5) c.srcb = 2'b10;
         else            c.aluop = alu_of(op);
         cyc.push_back(c); rdy.push_back(1'($urandom)); zv.push_back(1'($urandom));
         c = '0; c.regw = 1'b1; c.rdst = (op != 4'd5); c.done = 1'b1;
         cyc.push_back(c); rdy.push_back(1'($urandom)); zv.push_back(1'($urandom));
      end else if (op == 4'd6 || op == 4'd7) begin
         c = '0; c.srca = 1'b1; c.srcb = 2'b10;
         cyc.push_back(c); rdy.push_back(1'($urandom)); zv.push_back(1'($urandom));
         for (int k = 0; k <= s; k++) begin
            c = '0; c.iord = 1'b1;
            if (op == 4'd6) c.mr = 1'b1;
            else begin c.mw = 1'b1; c.done = (k == s); end
            cyc.push_back(c); rdy.push_back(k == s); zv.push_back(1'($urandom));
         end
         if (op == 4'd6) begin
            c = '0; c.regw = 1'b1; c.m2r = 1'b1; c.done = 1'b1;
            cyc.push_back(c); rdy.push_back(1'($urandom)); zv.push_back(1'($urandom));
         end
      end else if (op == 4'd8 || op == 4'd9) begin
         c = '0; c.srca = 1'b1; c.aluop = 4'b0100; c.pcsrc = 2'b01; c.done = 1'b1;
         c.pcen = (op == 4'd8) ? z : !z;
         cyc.push_back(c); rdy.push_back(1'($urandom)); zv.push_back(z);
      end else if (op == 4'd10) begin
         c = '0; c.pcsrc = 2'b10; c.pcen = 1'b1; c.done = 1'b1;
         cyc.push_back(c); rdy.push_back(1'($urandom)); zv.push_back(1'($urandom));
      end
      foreach (cyc[i]) sb.push_back(mk(cyc[i], mcnt));
      if (!ill) mcnt = mcnt + 1'b1;
      for (int i = 0; i < cyc.size(); i++) begin
         opcode = op;
         mem_ready = rdy[i];
         zero = zv[i];
         if (i == abort_at) begin
            @(negedge clk);
            #1;
            hold_reset();
            return;
         end
         @(posedge clk);
         #1;
      end
   endtask

   // driver: directed cases first, then random instruction stream, then a mid-write reset
   initial begin
      run = 1'b1;
      #2 hold_reset();
      run_instr(4'd0, 0, 0, 1'b0, -1);
      run_instr(4'd6, 0, 3, 1'b0, -1);
      run_instr(4'd8, 0, 0, 1'b1, -1);
      run_instr(4'd8, 0, 0, 1'b0, -1);
      run_instr(4'd9, 0, 0, 1'b1, -1);
      run_instr(4'd9, 0, 0, 1'b0, -1);
      run_instr(4'd12, 0, 0, 1'b0, -1);
      run_instr(4'd7, 2, 1, 1'b0, -1);
      run_instr(4'd10, 1, 0, 1'b0, -1);
      for (int n = 0; n < 250; n++) begin
         int f, s;
         f = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         s = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
         run_instr(4'($urandom_range(0, 15)), f, s, 1'($urandom), -1);
      end
      run_instr(4'd7, 0, 5, 1'b0, 4);
      run_instr(4'd10, 0, 0, 1'b0, -1);
      run_instr(4'd3, 0, 0, 1'b0, -1);
      run_instr(4'd5, 1, 0, 1'b0, -1);
      run = 1'b0;
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
